// File: rtl/disp_mux_ctrl.sv
// disp_mux_ctrl: multiplexed common-anode seven-segment display controller
// on the picoVersat parallel peripheral bus.
//
// One 8-bit register per digit (addr 0..DIGITS-1) and a control register
// (addr DIGITS). Scans DIGITS digits with a programmable slot length, hex
// font, decimal point, per-digit blanking, brightness duty cycle and a
// one-cycle all-off gap at the start of every slot to avoid ghosting.
//
// Optional feature: define DISP_BLINK_EN to build the per-digit blink logic.
// Without it, digit bit 6 is not stored and always reads 0.
module disp_mux_ctrl #(
  parameter int DIGITS       = 4,
  parameter int DIV          = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic [7:0]        Disp,
  output logic [DIGITS-1:0] Disp_sel
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2(DIGITS);
  localparam int SLOT  = DIV / 16;

`ifdef DISP_BLINK_EN
  localparam logic [7:0] DIG_MASK = 8'h7F;
`else
  localparam logic [7:0] DIG_MASK = 8'h3F;
`endif

  localparam logic [7:0] DIG_RST  = 8'h20;

  // Active-low hex font, {dp,g,f,e,d,c,b,a}, dp off.
  function automatic logic [7:0] hex_font(input logic [3:0] v);
    case (v)
      4'h0: hex_font = 8'hC0;
      4'h1: hex_font = 8'hF9;
      4'h2: hex_font = 8'hA4;
      4'h3: hex_font = 8'hB0;
      4'h4: hex_font = 8'h99;
      4'h5: hex_font = 8'h92;
      4'h6: hex_font = 8'h82;
      4'h7: hex_font = 8'hF8;
      4'h8: hex_font = 8'h80;
      4'h9: hex_font = 8'h90;
      4'hA: hex_font = 8'h88;
      4'hB: hex_font = 8'h83;
      4'hC: hex_font = 8'hC6;
      4'hD: hex_font = 8'hA1;
      4'hE: hex_font = 8'h86;
      default: hex_font = 8'h8E;
    endcase
  endfunction

  // Register state
  logic [7:0]        digit_q [DIGITS];
  logic [7:0]        digit_d [DIGITS];
  logic              en_q, en_d;
  logic [3:0]        bright_q, bright_d;
  logic [7:0]        dout_q, dout_d;

  // Scan state and registered outputs
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        disp_q, disp_d;
  logic [DIGITS-1:0] sel_q, sel_d;

  logic              wr_en, rd_en;
  logic              cnt_last;
  logic [7:0]        rd_data;
  logic [7:0]        cur;
  logic [31:0]       on_lim;
  logic              blink_sup;
  logic              drive;

  assign wr_en    = sel & we;
  assign rd_en    = sel & ~we;
  assign cnt_last = (cnt_q == CNT_W'(DIV - 1));

  // Register writes and read-data selection for the bus.
  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    for (int k = 0; k < DIGITS; k++) digit_d[k] = digit_q[k];
    en_d     = en_q;
    bright_d = bright_q;
    rd_data  = 8'h00;
    for (int k = 0; k < DIGITS; k++) begin
      if (wr_en && addr == ADDR_W'(k)) digit_d[k] = data_in & DIG_MASK;
      if (addr == ADDR_W'(k)) rd_data = digit_q[k];
    end
    if (wr_en && addr == ADDR_W'(DIGITS)) begin
      en_d     = data_in[0];
      bright_d = data_in[7:4];
    end
    if (addr == ADDR_W'(DIGITS)) rd_data = {bright_q, 3'b000, en_q};
    dout_d = rd_en ? rd_data : dout_q;
  end

  // Slot counter and digit index; both parked at 0 while disabled.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!en_q) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_last) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

`ifdef DISP_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BF_W-1:0] frame_q, frame_d;
  logic            blink_phase_q, blink_phase_d;
  logic            frame_end;

  assign frame_end = cnt_last & (idx_q == IDX_W'(DIGITS - 1));

  // Frame counter: toggle the blink phase every BLINK_FRAMES full frames.
  always_comb begin
    frame_d       = frame_q;
    blink_phase_d = blink_phase_q;
    if (!en_q) begin
      frame_d       = '0;
      blink_phase_d = 1'b0;
    end else if (frame_end) begin
      if (frame_q == BF_W'(BLINK_FRAMES - 1)) begin
        frame_d       = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_d = frame_q + BF_W'(1);
      end
    end
  end

  // Blink state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q       <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      frame_q       <= frame_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_sup = blink_phase_q & cur[6];
`else
  logic unused_blink_bit;
  assign unused_blink_bit = cur[6];
  assign blink_sup        = 1'b0;
`endif

  logic unused_bit7;
  assign unused_bit7 = cur[7];

  // Segment/anode decode from the current registered scan and digit state.
  always_comb begin
    cur = 8'h00;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) cur = digit_q[k];
    end
    on_lim = (32'(bright_q) + 32'd1) * 32'(SLOT);
    drive  = en_q && (cnt_q != '0) && (32'(cnt_q) < on_lim) &&
             !cur[5] && !blink_sup;
    disp_d = 8'hFF;
    sel_d  = '1;
    if (drive) begin
      disp_d = hex_font(cur[3:0]) & {~cur[4], 7'h7F};
      sel_d  = ~(DIGITS'(1) << idx_q);
    end
  end

  // State register for bus registers, scan counters and outputs.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the digit register array is reset because its power-up
      // content (blank) is architecturally visible.
      for (int k = 0; k < DIGITS; k++) digit_q[k] <= DIG_RST;
      en_q     <= 1'b1;
      bright_q <= 4'hF;
      dout_q   <= 8'h00;
      cnt_q    <= '0;
      idx_q    <= '0;
      disp_q   <= 8'hFF;
      sel_q    <= '1;
    end else begin
      for (int k = 0; k < DIGITS; k++) digit_q[k] <= digit_d[k];
      en_q     <= en_d;
      bright_q <= bright_d;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      sel_q    <= sel_d;
    end
  end

  assign data_out = dout_q;
  assign Disp     = disp_q;
  assign Disp_sel = sel_q;

endmodule

// File: doc/disp_mux_ctrl.md
# disp_mux_ctrl

Parametrised multiplexed seven-segment display controller, successor to the fixed 4-digit hookup on the top-level `Disp`/`Disp_sel` pins. It sits on the picoVersat parallel peripheral bus and holds one register per digit plus a control register. It scans `DIGITS` common-anode digits with a programmable refresh slot, hex decode, a decimal point, per-digit blanking, brightness duty and a one-cycle anti-ghosting gap.

## Interface
Parameters:
- `DIGITS`, 4: number of digits scanned; range 2..8.
- `DIV`, 50000: clock cycles per digit slot; must be a multiple of 16 and at least 32.
- `BLINK_FRAMES`, 64: full scan frames per blink half-period; used only with `DISP_BLINK_EN`.
- `ADDR_W`, 4: address width; must satisfy 2**ADDR_W > DIGITS.

Ports (clock and reset first):
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `sel` in 1: peripheral select.
- `we` in 1: write enable, qualified by `sel`.
- `addr` in ADDR_W: register address.
- `data_in` in 8: write data.
- `data_out` out 8: registered read data.
- `Disp` out 8: segments, active-low, {dp,g,f,e,d,c,b,a}.
- `Disp_sel` out DIGITS: digit anodes, active-low, one-hot when on.

## Operation
- Digit register `k` (addr 0..DIGITS-1) has these fields:
  - bits [3:0]: hex value.
  - bit 4: dp.
  - bit 5: blank.
  - bit 6: blink.
  - bit 7: reads 0.
- Control register (addr DIGITS) has these fields:
  - bit 0: enable.
  - bits [7:4]: bright (0..15).
  - other bits read 0.
- Reset values:
  - every digit register = 0x20 (blank).
  - control = 0xF1.
  - `Disp` = 0xFF, `Disp_sel` = all ones, `data_out` = 0x00.
  - slot counter, digit index and blink state = 0.
- Writes:
  - `sel & we` updates the addressed register at the rising edge.
  - Addresses above DIGITS are ignored.
- Reads:
  - `sel & ~we` loads `data_out` at the rising edge with the addressed register.
  - Out-of-range addresses return 0x00.
  - `data_out` holds its value otherwise.
- Scan:
  - Slot counter `cnt` runs 0..DIV-1 and wraps.
  - On wrap, the digit index advances 0,1,..,DIGITS-1 and wraps to 0.
- Digit `k` is driven (its `Disp_sel` bit low) when all of these hold:
  - enable = 1
  - cnt ≠ 0 (cnt = 0 is the anti-ghost gap: all anodes off)
  - cnt < (bright+1)·(DIV/16)
  - blank = 0
  - not suppressed by blink
- Segments:
  - Standard hex font, active-low; for example 0 → 0xC0, 8 → 0x80, F → 0x8E.
  - dp = 1 clears bit 7.
  - `Disp` = 0xFF whenever no digit is driven.
- Enable cleared:
  - All outputs go off.
  - `cnt`, the digit index and the blink counter are held at 0.
  - When re-enabled, the scan restarts at digit 0, cnt 0.
- A write to the currently scanned digit is visible on `Disp` in the cycle after the write edge; there is no waiting for the slot boundary.

## Timing
- `Disp`/`Disp_sel` are registered: they are a one-cycle function of the registered `cnt`, digit index and digit register state.
- Read latency is 1 cycle.
- A frame is DIGITS·DIV cycles.
- With bright = 15, a digit is on for DIV-1 cycles per slot. With bright = 0, it is on for DIV/16-1 cycles.
- When a write and the slot wrap occur in the same cycle, both take effect.
- Asserting `rst` mid-scan forces reset values immediately (asynchronous). Outputs are released on the first edge after deassertion.

## Configuration
- `DISP_BLINK_EN` defined:
  - A frame counter toggles `blink_phase` every BLINK_FRAMES frames.
  - While `blink_phase` = 1, digits with blink = 1 are treated as blanked.
  - `blink_phase` resets to 0 and is held at 0 while disabled.
- `DISP_BLINK_EN` undefined:
  - No blink logic is built.
  - Bit 6 is not stored: writes are ignored and reads return 0.

## Test plan
- Reset: with DIGITS=4 and DIV=32, assert `rst`=0 mid-scan → `Disp`=0xFF and `Disp_sel`=4'hF immediately. Reading addr 4 returns 0xF1; reading addr 0 returns 0x20.
- Scan: write 0x01,0x02,0x03,0x04 to addr 0..3 → digits 0..3 show 0xF9,0xA4,0xB0,0x99 in turn for 31 cycles each. `Disp_sel` is 4'hF for one cycle at each slot start. The order wraps 3→0.
- Brightness and dp: write control 0x31 and digit 0 = 0x18 → digit 0 is on for cnt 1..7 with `Disp`=0x00 and off for cnt 8..31.
- Boundaries:
  - A write to addr 9 leaves all registers unchanged; reading it returns 0x00.
  - Writing control 0x00 gives all-off outputs; writing 0xF1 again restarts the scan at digit 0.
- Blink: with `DISP_BLINK_EN` defined and BLINK_FRAMES=2, set digit 1 = 0x45 → digit 1 shows 0x92 for 2 frames, then is dark for 2 frames, repeating. Without the macro, the digit is always lit and reads back 0x05.
